// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO, LSB first, programmable bit period
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               en,
  input  logic [15:0]        prescaler,
  input  logic [7:0]         wdata,
  input  logic               wr,
  input  logic               clr_ovf,
  output logic               tx,
  output logic               busy,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               ovf
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wptr, rptr;
  logic [15:0] per, cnt;
  logic [7:0] sh;
  logic [2:0] idx;
  logic push, pop, bit_end;
  assign level = wptr - rptr;
  assign full = level[FIFO_AW];
  assign empty = level == '0;
  assign bit_end = cnt == '0;
  assign push = wr && !full;
  // a new frame starts from IDLE or straight out of the last stop-bit cycle
  assign pop = en && !empty && (state == IDLE || (state == STOP && bit_end));
  always_ff @(posedge HCLK)
    if (push) mem[wptr[FIFO_AW-1:0]] <= wdata;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wptr <= '0;
      rptr <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      ovf <= (wr && full) || (ovf && !clr_ovf);
    end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      tx <= 1'b1;
      busy <= 1'b0;
      per <= '0;
      cnt <= '0;
      sh <= '0;
      idx <= '0;
    end else if (pop) begin
      state <= START;
      sh <= mem[rptr[FIFO_AW-1:0]];
      per <= prescaler;
      cnt <= prescaler;
      tx <= 1'b0;
      busy <= 1'b1;
    end else if (state != IDLE) begin
      if (!bit_end) cnt <= cnt - 1'b1;
      else begin
        cnt <= per;
        case (state)
          START: begin
            state <= DATA;
            idx <= '0;
            tx <= sh[0];
            sh <= sh >> 1;
          end
          DATA: if (idx == 3'd7) begin
            state <= STOP;
            tx <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
            tx <= sh[0];
            sh <= sh >> 1;
          end
          default: begin
            state <= IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
endmodule
